// File: rtl/simple_axi_host_arbiter.sv
// Round-robin arbiter that shares one simple_axi_master host port among NUM_REQ requesters.
// The winner's request is latched, run on the host, and acked once with the captured status.
module simple_axi_host_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [2*NUM_REQ-1:0]      i_req_rw,
    input  logic [ADDR_W*NUM_REQ-1:0] i_req_addr,
    input  logic [3*NUM_REQ-1:0]      i_req_size,
    input  logic [DATA_W*NUM_REQ-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]        o_req_ack,
    output logic [DATA_W-1:0]         o_req_rdata,
    output logic                      o_req_error,
    output logic                      o_req_invalid,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic                      o_busy,
    output logic [ADDR_W-1:0]         o_host_addr,
    output logic [2:0]                o_host_size,
    output logic [DATA_W-1:0]         o_host_wdata,
    output logic [1:0]                o_host_rw,
    output logic                      o_host_clear,
    input  logic [DATA_W-1:0]         i_host_rdata,
    input  logic                      i_host_wait,
    input  logic                      i_host_done,
    input  logic                      i_host_invalid,
    input  logic                      i_host_error
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] GRANT_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, REJECT, ISSUE, WAIT, CLEAR, SETTLE} state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [2:0]         size_reg, size_next;
    logic [DATA_W-1:0]  wdata_reg, wdata_next;
    logic [1:0]         rw_reg, rw_next;
    logic [DATA_W-1:0]  rdata_reg, rdata_next;
    logic               error_reg, error_next;
    logic               invalid_reg, invalid_next;
    logic               settle_cnt_reg, settle_cnt_next;
    logic               repulse_reg, repulse_next;

    logic [NUM_REQ-1:0] eligible;
    logic [1:0]         req_rw    [NUM_REQ];
    logic [ADDR_W-1:0]  req_addr  [NUM_REQ];
    logic [2:0]         req_size  [NUM_REQ];
    logic [DATA_W-1:0]  req_wdata [NUM_REQ];

    // The wait flag is informational; transitions key off done/invalid only.
    logic unused_host_wait;
    assign unused_host_wait = i_host_wait;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_rw[gi]    = i_req_rw[2*gi +: 2];
            assign req_addr[gi]  = i_req_addr[ADDR_W*gi +: ADDR_W];
            assign req_size[gi]  = i_req_size[3*gi +: 3];
            assign req_wdata[gi] = i_req_wdata[DATA_W*gi +: DATA_W];
            assign eligible[gi]  = i_req_valid[gi] && (i_i_rw_nonzero(i_req_rw[2*gi +: 2]));
        end
    endgenerate

    function automatic logic i_i_rw_nonzero(input logic [1:0] rw);
        return rw != 2'b00;
    endfunction

    // Rotating priority: lowest eligible index at or above the pointer, else lowest overall.
    logic             found_hi, found_lo;
    logic [PTR_W-1:0] win_hi, win_lo, winner;
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found_lo = 1'b1;
                win_lo   = PTR_W'(i);
                if (PTR_W'(i) >= ptr_reg) begin
                    found_hi = 1'b1;
                    win_hi   = PTR_W'(i);
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    logic host_status;
    assign host_status = i_host_done | i_host_invalid | i_host_error;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            grant_reg      <= '0;
            addr_reg       <= '0;
            size_reg       <= '0;
            wdata_reg      <= '0;
            rw_reg         <= '0;
            rdata_reg      <= '0;
            error_reg      <= 1'b0;
            invalid_reg    <= 1'b0;
            settle_cnt_reg <= 1'b0;
            repulse_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            grant_reg      <= grant_next;
            addr_reg       <= addr_next;
            size_reg       <= size_next;
            wdata_reg      <= wdata_next;
            rw_reg         <= rw_next;
            rdata_reg      <= rdata_next;
            error_reg      <= error_next;
            invalid_reg    <= invalid_next;
            settle_cnt_reg <= settle_cnt_next;
            repulse_reg    <= repulse_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        grant_next      = grant_reg;
        addr_next       = addr_reg;
        size_next       = size_reg;
        wdata_next      = wdata_reg;
        rw_next         = rw_reg;
        rdata_next      = rdata_reg;
        error_next      = error_reg;
        invalid_next    = invalid_reg;
        settle_cnt_next = settle_cnt_reg;
        repulse_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (found_lo) begin
                    addr_next  = req_addr[winner];
                    size_next  = req_size[winner];
                    wdata_next = req_wdata[winner];
                    rw_next    = req_rw[winner];
                    grant_next = GRANT_ONE << winner;
                    ptr_next   = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    state_next = (req_rw[winner] == 2'b11) ? REJECT : ISSUE;
                end
            end
            REJECT: begin
                grant_next = '0;
                state_next = IDLE;
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (i_host_done || i_host_invalid) begin
                    rdata_next   = (rw_reg == 2'b01) ? '0 : i_host_rdata;
                    error_next   = i_host_error;
                    invalid_next = i_host_invalid;
                    state_next   = CLEAR;
                end
            end
            CLEAR: begin
                grant_next      = '0;
                settle_cnt_next = 1'b0;
                state_next      = SETTLE;
            end
            SETTLE: begin
                // Status that survives two sampled cycles gets another clear pulse.
                if (!host_status) begin
                    settle_cnt_next = 1'b0;
                    state_next      = IDLE;
                end else if (settle_cnt_reg) begin
                    settle_cnt_next = 1'b0;
                    repulse_next    = 1'b1;
                end else begin
                    settle_cnt_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_grant       = grant_reg;
    assign o_busy        = (state_reg != IDLE);
    assign o_req_ack     = (state_reg == CLEAR || state_reg == REJECT) ? grant_reg : '0;
    assign o_req_rdata   = (state_reg == CLEAR) ? rdata_reg : '0;
    assign o_req_error   = (state_reg == REJECT) || (state_reg == CLEAR && error_reg);
    assign o_req_invalid = (state_reg == REJECT) || (state_reg == CLEAR && invalid_reg);
    assign o_host_rw     = (state_reg == ISSUE || state_reg == WAIT) ? rw_reg : 2'b00;
    assign o_host_clear  = (state_reg == CLEAR) || repulse_reg;
    assign o_host_addr   = addr_reg;
    assign o_host_size   = size_reg;
    assign o_host_wdata  = wdata_reg;

endmodule

// File: tb/tb_simple_axi_host_arbiter.sv
// Bench for simple_axi_host_arbiter: behavioural host/slave model plus a round-robin
// scoreboard that predicts the winner order, status and read data of every transaction.
module tb_simple_axi_host_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [2*N-1:0]  req_rw;
    logic [AW*N-1:0] req_addr;
    logic [3*N-1:0]  req_size;
    logic [DW*N-1:0] req_wdata;
    logic [N-1:0]    req_ack;
    logic [DW-1:0]   req_rdata;
    logic            req_error, req_invalid;
    logic [N-1:0]    grant;
    logic            busy;
    logic [AW-1:0]   host_addr;
    logic [2:0]      host_size;
    logic [DW-1:0]   host_wdata;
    logic [1:0]      host_rw;
    logic            host_clear;
    logic [DW-1:0]   host_rdata;
    logic            host_wait, host_done, host_invalid, host_error;

    simple_axi_host_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_req_valid(req_valid), .i_req_rw(req_rw), .i_req_addr(req_addr),
        .i_req_size(req_size), .i_req_wdata(req_wdata),
        .o_req_ack(req_ack), .o_req_rdata(req_rdata), .o_req_error(req_error),
        .o_req_invalid(req_invalid), .o_grant(grant), .o_busy(busy),
        .o_host_addr(host_addr), .o_host_size(host_size), .o_host_wdata(host_wdata),
        .o_host_rw(host_rw), .o_host_clear(host_clear),
        .i_host_rdata(host_rdata), .i_host_wait(host_wait), .i_host_done(host_done),
        .i_host_invalid(host_invalid), .i_host_error(host_error)
    );

    // Requester stimulus tables
    logic [1:0]    op      [N];
    logic [AW-1:0] addr_a  [N];
    logic [2:0]    size_a  [N];
    logic [DW-1:0] wdata_a [N];
    logic [1:0]    resp    [N];   // slave response for that requester: 0 ok, 2 slverr, 3 decerr

    int passed;
    int total;
    int model_ptr;
    int slave_delay;

    // ---------------- behavioural host + slave ----------------
    logic [7:0]    mem [256];
    bit            mem_ready;
    logic          s_busy;
    int            s_cnt;
    logic [7:0]    s_addr;
    logic [2:0]    s_size;
    logic [1:0]    s_rw;
    logic [DW-1:0] s_wdata;
    logic [1:0]    s_resp;

    assign host_wait = s_busy;

    function automatic logic [63:0] slave_read(input logic [7:0] a, input logic [2:0] s);
        logic [63:0] v = '0;
        for (int k = 0; k < 8; k++)
            if (k < (1 << s)) v[8*k +: 8] = mem[a + 8'(k)];
        return v;
    endfunction

    function automatic logic [1:0] resp_of_grant();
        for (int i = 0; i < N; i++)
            if (grant[i]) return resp[i];
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            host_done <= 1'b0; host_invalid <= 1'b0; host_error <= 1'b0;
            host_rdata <= '0; s_busy <= 1'b0; s_cnt <= 0;
            if (!mem_ready) begin
                for (int b = 0; b < 256; b++) mem[b] <= 8'(b * 37 + 11);
                mem_ready <= 1'b1;
            end
        end else if (host_clear) begin
            host_done <= 1'b0; host_invalid <= 1'b0; host_error <= 1'b0;
            host_rdata <= '0;
        end else if (s_busy) begin
            if (s_cnt == 0) begin
                s_busy       <= 1'b0;
                host_done    <= 1'b1;
                host_error   <= s_resp[1];
                host_invalid <= (s_resp == 2'b11);
                if (s_resp == 2'b00) begin
                    if (s_rw == 2'b01) begin
                        for (int k = 0; k < 8; k++)
                            if (k < (1 << s_size)) mem[s_addr + 8'(k)] <= s_wdata[8*k +: 8];
                    end else begin
                        host_rdata <= slave_read(s_addr, s_size);
                    end
                end
            end else begin
                s_cnt <= s_cnt - 1;
            end
        end else if (host_rw != 2'b00 && !(host_done || host_invalid || host_error)) begin
            if ((host_addr[7:0] & ((8'd1 << host_size) - 8'd1)) != 8'd0) begin
                host_invalid <= 1'b1;
                host_error   <= 1'b1;
            end else begin
                s_busy  <= 1'b1;
                s_cnt   <= slave_delay;
                s_addr  <= host_addr[7:0];
                s_size  <= host_size;
                s_rw    <= host_rw;
                s_wdata <= host_wdata;
                s_resp  <= resp_of_grant();
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [256];

    function automatic logic [63:0] ref_read(input logic [7:0] a, input logic [2:0] s);
        logic [63:0] v = '0;
        for (int k = 0; k < (1 << s); k++) v[8*k +: 8] = ref_mem[a + 8'(k)];
        return v;
    endfunction

    function automatic int model_pick(input logic [N-1:0] p);
        for (int k = 0; k < N; k++) begin
            int idx = (model_ptr + k) % N;
            if (p[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_rw[2*i +: 2]     = op[i];
            req_addr[AW*i +: AW] = addr_a[i];
            req_size[3*i +: 3]   = size_a[i];
            req_wdata[DW*i +: DW] = wdata_a[i];
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] o, input logic [AW-1:0] a,
                           input logic [2:0] s, input logic [DW-1:0] d, input logic [1:0] r);
        op[i] = o; addr_a[i] = a; size_a[i] = s; wdata_a[i] = d; resp[i] = r;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_ack"}, req_ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_host_rw"}, host_rw, 0);
        chk({tag, "_host_clear"}, host_clear, 0);
        chk({tag, "_host_addr"}, host_addr, 0);
        chk({tag, "_status"}, {req_error, req_invalid}, 0);
    endtask

    // Hold the masked requests, then collect one ack per eligible requester.
    task automatic run_round(input logic [N-1:0] mask, input bit drop_early);
        logic [N-1:0]  pending;
        logic [DW-1:0] exp_rd;
        logic          exp_err, exp_inv, misal, seen_grant, got;
        logic [7:0]    e_addr;
        int            w, clr_cnt;
        @(negedge clk);
        drive();
        req_valid = mask;
        pending = '0;
        for (int i = 0; i < N; i++)
            if (mask[i] && op[i] != 2'b00) pending[i] = 1'b1;
        while (pending != '0) begin
            w = model_pick(pending);
            e_addr = addr_a[w][7:0];
            misal = (e_addr & ((8'd1 << size_a[w]) - 8'd1)) != 8'd0;
            exp_rd = '0; exp_err = 1'b0; exp_inv = 1'b0;
            if (op[w] == 2'b11 || misal) begin
                exp_err = 1'b1; exp_inv = 1'b1;
            end else if (resp[w] == 2'b10) begin
                exp_err = 1'b1;
            end else if (resp[w] == 2'b11) begin
                exp_err = 1'b1; exp_inv = 1'b1;
            end else if (op[w] == 2'b10) begin
                exp_rd = ref_read(e_addr, size_a[w]);
            end else begin
                for (int k = 0; k < (1 << size_a[w]); k++)
                    ref_mem[e_addr + 8'(k)] = wdata_a[w][8*k +: 8];
            end
            seen_grant = 1'b0; got = 1'b0; clr_cnt = 0;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                if (host_clear) clr_cnt++;
                if (!seen_grant && grant != '0) begin
                    seen_grant = 1'b1;
                    chk("grant_owner", grant, 64'(1) << w);
                    chk("host_rw_at_grant", host_rw, (op[w] == 2'b11) ? 64'd0 : 64'(op[w]));
                    if (drop_early && op[w] != 2'b11) begin
                        req_valid[w] = 1'b0;
                        addr_a[w] = addr_a[w] ^ 32'h40;
                        wdata_a[w] = ~wdata_a[w];
                        drive();
                    end
                end
                if (req_ack != '0) begin
                    got = 1'b1;
                    chk("ack_onehot", req_ack, 64'(1) << w);
                    chk("ack_rdata", req_rdata, exp_rd);
                    chk("ack_error", req_error, exp_err);
                    chk("ack_invalid", req_invalid, exp_inv);
                    chk("clear_pulses", clr_cnt, (op[w] == 2'b11) ? 64'd0 : 64'd1);
                    $display("txn req%0d op=%0d addr=%0h size=%0d rdata=%0h err=%0b inv=%0b",
                             w, op[w], e_addr, size_a[w], req_rdata, req_error, req_invalid);
                end
            end
            if (!got) begin
                chk("ack_timeout", 0, 1);
                req_valid = '0;
                return;
            end
            model_ptr = (w + 1) % N;
            pending[w] = 1'b0;
            req_valid[w] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("busy_drops", busy, 0);
        req_valid = '0;
    endtask

    initial begin
        logic got;
        passed = 0; total = 0; model_ptr = 0; slave_delay = 2;
        req_valid = '0; req_rw = '0; req_addr = '0; req_size = '0; req_wdata = '0;
        for (int i = 0; i < N; i++) set_req(i, 2'b00, '0, 3'd0, '0, 2'b00);
        for (int b = 0; b < 256; b++) ref_mem[b] = 8'(b * 37 + 11);
        #12;
        check_idle("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Single write
        set_req(0, 2'b01, 32'h10, 3'd2, 64'h11111111, 2'b00);
        run_round(4'b0001, 1'b0);
        for (int k = 0; k < 4; k++) chk("mem_write", mem[8'h10 + 8'(k)], 8'h11);

        // Round robin over four reads, then requester 0 again
        for (int i = 0; i < N; i++) set_req(i, 2'b10, 32'(i * 8), 3'd3, '0, 2'b00);
        run_round(4'b1111, 1'b0);
        set_req(0, 2'b10, 32'h0, 3'd3, '0, 2'b00);
        run_round(4'b0001, 1'b0);

        // Misaligned write followed by a normal read in the same round
        set_req(2, 2'b01, 32'h1, 3'd1, 64'hBEEF, 2'b00);
        set_req(0, 2'b10, 32'h0, 3'd2, '0, 2'b00);
        run_round(4'b0101, 1'b0);
        chk("misaligned_mem1", mem[1], ref_mem[1]);
        chk("misaligned_mem2", mem[2], ref_mem[2]);

        // Slave error responses
        set_req(0, 2'b01, 32'h30, 3'd3, 64'h0123456789ABCDEF, 2'b10);
        run_round(4'b0001, 1'b0);
        set_req(1, 2'b10, 32'h38, 3'd3, '0, 2'b11);
        run_round(4'b0010, 1'b0);

        // Illegal op
        set_req(1, 2'b11, 32'h40, 3'd2, '0, 2'b00);
        run_round(4'b0010, 1'b0);

        // rw=00 with valid is ignored; payload change after grant is ignored
        set_req(3, 2'b00, 32'h50, 3'd2, '0, 2'b00);
        set_req(2, 2'b01, 32'h48, 3'd3, 64'hCAFEF00DDEADBEEF, 2'b00);
        run_round(4'b1100, 1'b1);
        set_req(2, 2'b10, 32'h48, 3'd3, '0, 2'b00);
        run_round(4'b0100, 1'b0);

        // Reset during WAIT
        slave_delay = 7;
        set_req(0, 2'b10, 32'h20, 3'd3, '0, 2'b00);
        @(negedge clk);
        drive();
        req_valid = 4'b0001;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (grant != '0) got = 1'b1;
        end
        chk("rst_grant_seen", got, 1);
        repeat (3) @(negedge clk);
        chk("rst_busy_in_wait", busy, 1);
        #2 rstn = 1'b0;
        #1;
        check_idle("mid_reset");
        req_valid = '0;
        repeat (2) @(negedge clk);
        chk("mid_reset_no_ack", req_ack, 0);
        rstn = 1'b1;
        model_ptr = 0;
        slave_delay = 2;
        set_req(0, 2'b10, 32'h20, 3'd3, '0, 2'b00);
        run_round(4'b0001, 1'b0);

        // Randomized rounds
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                int sel;
                int sz;
                int ad;
                sel = $urandom_range(0, 9);
                op[i] = (sel < 4) ? 2'b10 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b11 : 2'b00;
                sz = $urandom_range(0, 3);
                ad = $urandom_range(0, 255) & ~((1 << sz) - 1);
                if ($urandom_range(0, 7) == 0) ad = ad | 1;
                size_a[i]  = 3'(sz);
                addr_a[i]  = AW'(ad);
                wdata_a[i] = {$urandom, $urandom};
                sel = $urandom_range(0, 7);
                resp[i] = (sel == 0) ? 2'b10 : (sel == 1) ? 2'b11 : 2'b00;
            end
            slave_delay = $urandom_range(0, 4);
            run_round(N'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/simple_axi_host_arbiter.md
Name: simple_axi_host_arbiter

Overview:
- Round-robin arbiter sharing one simple_axi_master host bus between NUM_REQ requesters (e.g. fetch, load/store, DMA).
- Latches a granted request and drives the host bus; waits for master completion; returns read data and status to the winner with a one-cycle ack.
- Pulses the master's clear so every transaction starts from a clean status.
- Sits between the requester interconnect and simple_axi_master, one instance per AXI port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 64, data width

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset; asynchronous, active-low
i_req_valid  in  NUM_REQ  per-requester request; held until matching ack
i_req_rw  in  2*NUM_REQ  per-requester op: 01 write, 10 read, 00 none, 11 illegal
i_req_addr  in  ADDR_W*NUM_REQ  per-requester address
i_req_size  in  3*NUM_REQ  per-requester size: 0 byte, 1 half, 2 word, 3 dword
i_req_wdata  in  DATA_W*NUM_REQ  per-requester write data
o_req_ack  out  NUM_REQ  one-hot, one-cycle completion pulse
o_req_rdata  out  DATA_W  read data, valid in the ack cycle
o_req_error  out  1  error status, valid in the ack cycle
o_req_invalid  out  1  invalid status, valid in the ack cycle
o_grant  out  NUM_REQ  one-hot owner, ISSUE through ack
o_busy  out  1  state != IDLE
o_host_addr  out  ADDR_W  to master i_addr
o_host_size  out  3  to master i_size
o_host_wdata  out  DATA_W  to master i_wdata
o_host_rw  out  2  to master i_rw
o_host_clear  out  1  to master i_clear
i_host_rdata  in  DATA_W  from master o_rdata
i_host_wait  in  1  from master o_wait
i_host_done  in  1  from master o_done
i_host_invalid  in  1  from master o_invalid
i_host_error  in  1  from master o_error

Behaviour:
- Reset (async, i_rstn=0): state IDLE, rr pointer=0. All outputs 0, including o_host_rw=00 and o_host_clear=0.
- Eligible requester: i_req_valid=1 and rw!=00. A request with rw=00 is ignored.
- Arbitration in IDLE: search starts at rr pointer, wraps modulo NUM_REQ, first eligible index wins.
  - At that edge: latch addr/size/wdata/rw, set o_grant, set pointer = winner+1 (wrap to 0 at NUM_REQ).
- States:
  - IDLE: choose a winner. If latched rw=11 go to REJECT, else go to ISSUE.
  - REJECT (1 cycle): ack the winner with invalid=1, error=1, rdata=0; no host activity; next state IDLE.
  - ISSUE: o_host_rw=latched op, address/size/wdata registered outputs; next state WAIT.
  - WAIT: hold o_host_rw and payload until i_host_done|i_host_invalid is sampled high.
    - At that edge: capture i_host_rdata (forced to 0 for writes), i_host_error and i_host_invalid; drop o_host_rw to 00; assert o_host_clear; go to CLEAR.
  - CLEAR (1 cycle): o_host_clear=1, o_req_ack[winner]=1 with captured status; next state SETTLE.
  - SETTLE: o_host_clear=0; return to IDLE once done=invalid=error=0 are sampled.
    - If status persists for 2 cycles, re-pulse o_host_clear.
- i_host_wait is informational only; it does not gate transitions.
- Latency: valid sampled in IDLE at edge N → o_host_rw nonzero during cycle N+1. Ack appears 1 cycle after done is sampled. Minimum gap between two grants: 2 cycles after ack.
- Requester changes to payload after grant are ignored. Deasserting valid before ack does not abort the transaction; the ack is still issued.
- New requests arriving while busy wait; no queueing beyond the held valid.
- Reset mid-operation aborts immediately to IDLE with no ack. simple_axi_master shares i_rstn.
- Only one outstanding transaction; the master is never given a new rw while its status is non-clear.

Test Plan:
- Single write: req0 rw=01, addr=0x10, size=2, wdata=0x11111111; slave OK → o_host_rw=01 until done, ack[0] pulses with error=0/invalid=0, clear pulses once, memory[0x10..0x13]=11 11 11 11.
- Round robin: req0..req3 held valid with reads of 0x0,0x8,0x10,0x18 → grants in order 0,1,2,3,0; never two acks in one cycle; each o_req_rdata matches memory.
- Misaligned: req2 write addr=0x01 size=1 → master sets invalid; ack[2] with invalid=1, error=1; memory unchanged; next request proceeds without a manual clear.
- SLVERR/DECERR: slave bresp=10 → ack error=1, invalid=0; rresp=11 → error=1, invalid=1; o_busy drops after SETTLE.
- Illegal op: req1 rw=11 → ack[1] one cycle after the grant with invalid=1, error=1; o_host_rw stays 00 throughout.
- Reset mid-WAIT: slave delay 7, assert i_rstn=0 during WAIT → all outputs 0 asynchronously, no ack; after release a new req0 read completes normally.
